// File: rtl/seg7_axil_slave.sv
// AXI4-Lite slave with four registers driving a 4-digit multiplexed 7-segment display.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module seg7_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_PRESCALE_RST     = 32'd49999
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [6:0]                      SEG_N,
  output logic                            DP_N,
  output logic [3:0]                      AN_N
);

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Active-low segment pattern, bit0 = a .. bit6 = g
  function automatic logic [6:0] hex7_n(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  4'hF: on = 7'h71;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  logic        awready_q, awready_d, bvalid_q, bvalid_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] digits_q, digits_d, ctrl_q, ctrl_d, prescale_q, prescale_d, scratch_q, scratch_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        wr_hs_s, rd_hs_s;
  logic [31:0] wmerge_s, rmux_s;
  logic [3:0]  blank_s, digit_s, dpen_s;
  logic        unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign wr_hs_s  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs_s  = arready_q & S_AXI_ARVALID;

  // AXI handshake state and register file next-state
  always_comb begin
    awready_d  = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    arready_d  = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    digits_d   = digits_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    scratch_d  = scratch_q;
    rdata_d    = rdata_q;
    wmerge_s   = 32'h0000_0000;
    rmux_s     = 32'h0000_0000;

    case (S_AXI_ARADDR[3:2])
      2'd0:    rmux_s = digits_q;
      2'd1:    rmux_s = ctrl_q;
      2'd2:    rmux_s = prescale_q;
      2'd3:    rmux_s = scratch_q;
      default: rmux_s = 32'h0000_0000;
    endcase

    if (wr_hs_s) begin
      case (S_AXI_AWADDR[3:2])
        2'd0:    begin wmerge_s = apply_strb(digits_q,   S_AXI_WDATA, S_AXI_WSTRB); digits_d   = wmerge_s; end
        2'd1:    begin wmerge_s = apply_strb(ctrl_q,     S_AXI_WDATA, S_AXI_WSTRB); ctrl_d     = wmerge_s; end
        2'd2:    begin wmerge_s = apply_strb(prescale_q, S_AXI_WDATA, S_AXI_WSTRB); prescale_d = wmerge_s; end
        2'd3:    begin wmerge_s = apply_strb(scratch_q,  S_AXI_WDATA, S_AXI_WSTRB); scratch_d  = wmerge_s; end
        default: wmerge_s = 32'h0000_0000;
      endcase
      bvalid_d = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    // Read samples registers before any same-cycle write lands
    if (rd_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rmux_s;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Scan counter, leading-zero mask and registered display decode
  always_comb begin
    if (cnt_q == prescale_q[15:0]) begin
      cnt_d = 16'h0000;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank_s = {digits_q[15:12] == 4'h0, digits_q[15:8] == 8'h00, digits_q[15:4] == 12'h000, 1'b0};
`else
    blank_s = 4'b0000;
`endif
    digit_s = digits_q[{idx_q, 2'b00} +: 4];
    dpen_s  = ctrl_q[7:4];
    an_d    = 4'hF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (ctrl_q[0] && !blank_s[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7_n(digit_s);
      dp_d  = ~dpen_s[idx_q];
    end else begin
      an_d  = 4'hF;
    end
  end

  // State registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      digits_q   <= 32'h0000_0000;
      ctrl_q     <= 32'h0000_0000;
      prescale_q <= C_PRESCALE_RST;
      scratch_q  <= 32'h0000_0000;
      cnt_q      <= 16'h0000;
      idx_q      <= 2'd0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      digits_q   <= digits_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign AN_N          = an_q;
  assign SEG_N         = seg_q;
  assign DP_N          = dp_q;

endmodule

// File: tb/tb_seg7_axil_slave.sv
// Directed self-checking bench for seg7_axil_slave (reset value of PRESCALE overridden
// so its low half is 0 and scanning is fast from reset).
module tb_seg7_axil_slave;

  localparam logic [31:0] PRST = 32'h0001_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = 4'h0;
  logic [2:0]  S_AXI_AWPROT = 3'b000;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = 32'h0;
  logic [3:0]  S_AXI_WSTRB = 4'h0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [3:0]  S_AXI_ARADDR = 4'h0;
  logic [2:0]  S_AXI_ARPROT = 3'b000;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic [6:0]  SEG_N;
  logic        DP_N;
  logic [3:0]  AN_N;

  int n_vec = 0;
  int n_err = 0;

  seg7_axil_slave #(.C_PRESCALE_RST(PRST)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .SEG_N(SEG_N), .DP_N(DP_N), .AN_N(AN_N)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_aw_w(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done = 1'b0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY && S_AXI_WREADY) done = 1'b1;
    end
    if (!done) check_val("awready_timeout", {31'b0, S_AXI_AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_b();
    bit done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) done = 1'b1;
    end
    if (!done) check_val("bvalid_timeout", {31'b0, S_AXI_BVALID}, 32'd1);
    else check_val("bresp", {30'b0, S_AXI_BRESP}, 32'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    axi_aw_w(a, d, s);
    axi_b();
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    bit done = 1'b0;
    d = 32'hDEAD_BEEF;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) done = 1'b1;
    end
    if (!done) check_val("arready_timeout", {31'b0, S_AXI_ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) done = 1'b1;
    end
    if (!done) check_val("rvalid_timeout", {31'b0, S_AXI_RVALID}, 32'd1);
    else check_val("rresp", {30'b0, S_AXI_RRESP}, 32'd0);
    d = S_AXI_RDATA;
    @(posedge ACLK); #1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check_val(tag, d, exp);
  endtask

  task automatic disp_chk(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    check_val({tag, "_an"}, {28'b0, AN_N}, {28'b0, an});
    check_val({tag, "_seg"}, {25'b0, SEG_N}, {25'b0, seg});
    check_val({tag, "_dp"}, {31'b0, DP_N}, {31'b0, dp});
  endtask

  task automatic find_digit0();
    bit done = 1'b0;
    for (int t = 0; t < 12 && !done; t++) begin
      @(negedge ACLK);
      if (AN_N == 4'hE) done = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK); ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  logic [31:0] rd;
  logic [3:0]  an_prev;
  int          n_cyc;

  initial begin
    // Reset state while held and after release
    repeat (3) @(negedge ACLK);
    disp_chk("rst_hold", 4'hF, 7'h7F, 1'b1);
    check_val("rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    check_val("rst_rvalid", {31'b0, S_AXI_RVALID}, 32'd0);
    check_val("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
    ARESET = 1'b0;
    read_chk("rst_digits", 4'h0, 32'h0);
    read_chk("rst_ctrl", 4'h4, 32'h0);
    read_chk("rst_prescale", 4'h8, PRST);
    read_chk("rst_scratch", 4'hC, 32'h0);

    // Byte strobes
    axi_write(4'hC, 32'hFFFF_FFFF, 4'b0101);
    read_chk("strb_0101", 4'hC, 32'h00FF_00FF);

    // Full-word writes to every register, low address bits ignored
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h5, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hF, 32'h4, 4'hF);
    read_chk("rw_digits", 4'h0, 32'h1);
    read_chk("rw_ctrl", 4'h4, 32'h2);
    read_chk("rw_prescale", 4'hA, 32'h3);
    read_chk("rw_scratch", 4'hC, 32'h4);

    // Backpressured write response blocks a second write
    S_AXI_BREADY = 1'b0;
    axi_aw_w(4'hC, 32'h1122_3344, 4'hF);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check_val("bp_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
      check_val("bp_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    axi_b();
    axi_write(4'hC, 32'h55, 4'hF);
    read_chk("bp_second", 4'hC, 32'h55);

    // Simultaneous write and read of one register returns the old value
    fork
      axi_write(4'hC, 32'hAA, 4'hF);
      axi_read(4'hC, rd);
    join
    check_val("rw_same_old", rd, 32'h55);
    read_chk("rw_same_new", 4'hC, 32'hAA);

    // Scanning every cycle with one decimal point
    do_reset();
    axi_write(4'h0, 32'h0000_ABCD, 4'hF);
    axi_write(4'h8, 32'h0, 4'hF);
    axi_write(4'h4, 32'h21, 4'hF);
    find_digit0();
    disp_chk("scan0", 4'hE, 7'h21, 1'b1);
    @(negedge ACLK); disp_chk("scan1", 4'hD, 7'h46, 1'b0);
    @(negedge ACLK); disp_chk("scan2", 4'hB, 7'h03, 1'b1);
    @(negedge ACLK); disp_chk("scan3", 4'h7, 7'h08, 1'b1);
    @(negedge ACLK); disp_chk("scan4", 4'hE, 7'h21, 1'b1);

    // Display disabled blanks everything
    axi_write(4'h4, 32'h20, 4'hF);
    repeat (2) @(negedge ACLK);
    disp_chk("disabled", 4'hF, 7'h7F, 1'b1);

    // PRESCALE=2 gives a three-cycle digit period
    axi_write(4'h8, 32'h2, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    @(negedge ACLK); an_prev = AN_N;
    for (int t = 0; t < 10 && AN_N == an_prev; t++) @(negedge ACLK);
    an_prev = AN_N;
    n_cyc = 0;
    for (int t = 0; t < 10 && (n_cyc == 0 || AN_N == an_prev); t++) begin
      @(negedge ACLK);
      n_cyc++;
    end
    check_val("prescale2_period", n_cyc, 32'd3);

    // Leading-zero handling
    do_reset();
    axi_write(4'h0, 32'h50, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    find_digit0();
    disp_chk("lz_d0", 4'hE, 7'h40, 1'b1);
    @(negedge ACLK); disp_chk("lz_d1", 4'hD, 7'h12, 1'b1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    @(negedge ACLK); disp_chk("lz_d2", 4'hF, 7'h7F, 1'b1);
    @(negedge ACLK); disp_chk("lz_d3", 4'hF, 7'h7F, 1'b1);
`else
    @(negedge ACLK); disp_chk("lz_d2", 4'hB, 7'h40, 1'b1);
    @(negedge ACLK); disp_chk("lz_d3", 4'h7, 7'h40, 1'b1);
`endif

    // Asynchronous reset mid-scan with a pending write response
    axi_write(4'h8, 32'h0, 4'hF);
    S_AXI_BREADY = 1'b0;
    axi_aw_w(4'hC, 32'h77, 4'hF);
    @(negedge ACLK);
    check_val("pre_rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    check_val("pre_rst_an_on", {31'b0, AN_N != 4'hF}, 32'd1);
    #2 ARESET = 1'b1;
    #1 disp_chk("async_rst", 4'hF, 7'h7F, 1'b1);
    check_val("async_rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    @(negedge ACLK); ARESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check_val("post_rst_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    read_chk("post_rst_prescale", 4'h8, PRST);
    read_chk("post_rst_scratch", 4'hC, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
